one_to_sixteen_deser: RTL and testbench

//   Sequential 1-to-N demultiplexer / deserializer; receive-side counterpart of the 16:1 mux tree.
//   A serial bit stream is produced by sweeping the mux select 0..15, with in[0] sent first.

---
 rtl/one_to_sixteen_deser.sv | 84 ++++++++
 tb/tb_one_to_sixteen_deser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/one_to_sixteen_deser.sv
// Serial-to-parallel deserializer: fills a 16-slot word from a bit stream (slot 0 first),
// with a one-cycle frame_done pulse and a direct single-bit address-mode write path.
module one_to_sixteen_deser #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  input  logic          addr_mode,
  input  logic [0:SW-1] sel_in,
  input  logic          clear,
  output logic [0:N-1]  out,
  output logic          frame_done,
  output logic [0:SW-1] slot,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [0:SW-1] LAST = SW'(N - 1);

  state_t        state_q, state_d;
  logic [0:N-1]  shadow_q, shadow_d;
  logic [0:N-1]  out_q, out_d;
  logic [0:SW-1] slot_q, slot_d;
  logic          auto_v, addr_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      out_q    <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      slot_q   <= slot_d;
    end
  end

  assign auto_v = din_valid & ~addr_mode;
  assign addr_v = din_valid &  addr_mode;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    slot_d   = slot_q;
    if (state_q == DONE) state_d = IDLE;
    if (clear) begin
      state_d = IDLE;
      slot_d  = '0;
    end else if (addr_v) begin
      out_d[sel_in] = din;
    end else if (auto_v) begin
      // slot_q is 0 in IDLE and DONE, so this also lands bit 0 of a new frame
      shadow_d[slot_q] = din;
      if (state_q == FILL) begin
        if (slot_q == LAST) begin
          out_d        = shadow_q;
          out_d[N-1]   = din;
          slot_d       = '0;
          state_d      = DONE;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end else begin
        slot_d  = SW'(1);
        state_d = FILL;
      end
    end
  end

  always_comb begin
    frame_done = (state_q == DONE);
    busy       = (state_q == FILL);
    out        = out_q;
    slot       = slot_q;
  end

endmodule

// File: tb/tb_one_to_sixteen_deser.sv
// Directed bench for one_to_sixteen_deser: auto frames, back-to-back, gaps, address mode, abort, reset.
module tb_one_to_sixteen_deser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        addr_mode = 1'b0;
  logic [0:3]  sel_in = '0;
  logic        clear = 1'b0;
  logic [0:15] out;
  logic        frame_done;
  logic [0:3]  slot;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  one_to_sixteen_deser #(.N(16), .SW(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .addr_mode(addr_mode), .sel_in(sel_in), .clear(clear),
    .out(out), .frame_done(frame_done), .slot(slot), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Apply one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic d, input logic am,
                       input logic [0:3] s, input logic clr);
    din_valid = v; din = d; addr_mode = am; sel_in = s; clear = clr;
    @(posedge clk); #1;
    din_valid = 1'b0; clear = 1'b0; addr_mode = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out !== 16'h0000 || slot !== 4'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_por: out=%h slot=%0d busy=%b fd=%b expected 0000/0/0/0", out, slot, busy, frame_done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_auto_frame;
    logic [0:15] w;
    w = 16'b1000000000000001;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, w[i], 1'b0, 4'd0, 1'b0);
      if (i < 15) begin
        tests++;
        if (busy !== 1'b1 || slot !== 4'(i + 1) || frame_done !== 1'b0) begin
          fails++;
          $display("FAIL auto_progress bit%0d: busy=%b slot=%0d fd=%b expected 1/%0d/0", i, busy, slot, frame_done, i + 1);
        end
      end
    end
    tests++;
    if (out !== 16'b1000000000000001 || frame_done !== 1'b1 || busy !== 1'b0 || slot !== 4'd0) begin
      fails++;
      $display("FAIL auto_done: out=%b fd=%b busy=%b slot=%0d expected 1000000000000001/1/0/0", out, frame_done, busy, slot);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL auto_pulse_width: fd=%b busy=%b expected 0/0", frame_done, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [0:15] a, b;
    int t_a, t_b;
    a = 16'hFFFF; b = 16'h00F0;
    t_a = -1; t_b = -1;
    for (int i = 0; i < 16; i++) drive(1'b1, a[i], 1'b0, 4'd0, 1'b0);
    tests++;
    if (out !== 16'hFFFF || frame_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_frame_a: out=%h fd=%b expected ffff/1", out, frame_done);
    end
    t_a = cyc_cnt;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, b[i], 1'b0, 4'd0, 1'b0);
      if (i == 0) begin
        tests++;
        if (busy !== 1'b1 || slot !== 4'd1 || frame_done !== 1'b0 || out !== 16'hFFFF) begin
          fails++;
          $display("FAIL b2b_first_bit_in_done: busy=%b slot=%0d fd=%b out=%h expected 1/1/0/ffff", busy, slot, frame_done, out);
        end
      end
      if (frame_done === 1'b1) t_b = cyc_cnt;
    end
    tests++;
    if (out !== 16'h00F0 || frame_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_frame_b: out=%h fd=%b expected 00f0/1", out, frame_done);
    end
    tests++;
    if (t_b - t_a !== 16) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d cycles expected 16", t_b - t_a);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_gapped;
    logic [0:15] w;
    int bad;
    w = 16'hA5A5;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, w[i], 1'b0, 4'd0, 1'b0);
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        if (i < 15 && (slot !== 4'(i + 1) || busy !== 1'b1)) bad++;
      end
      if (i == 15) begin
        tests++;
        if (out !== 16'hA5A5) begin
          fails++;
          $display("FAIL gapped_out: out=%h expected a5a5", out);
        end
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL gapped_slot_hold: %0d idle cycles with wrong slot/busy, expected 0", bad);
    end
  endtask

  task automatic test_addr_mode;
    logic [0:15] w;
    int fd_seen;
    w = 16'hC3C3;
    fd_seen = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) drive(1'b1, w[i], 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0011, 1'b0);
    if (frame_done === 1'b1) fd_seen++;
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0);
    if (frame_done === 1'b1) fd_seen++;
    tests++;
    if (out !== 16'b0001000000000001) begin
      fails++;
      $display("FAIL addr_out: out=%b expected 0001000000000001", out);
    end
    tests++;
    if (fd_seen !== 0 || slot !== 4'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL addr_side_effects: fd_seen=%0d slot=%0d busy=%b expected 0/3/1", fd_seen, slot, busy);
    end
    for (int i = 3; i < 16; i++) drive(1'b1, w[i], 1'b0, 4'd0, 1'b0);
    tests++;
    if (out !== 16'hC3C3 || frame_done !== 1'b1) begin
      fails++;
      $display("FAIL addr_resume_frame: out=%h fd=%b expected c3c3/1", out, frame_done);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_abort;
    logic [0:15] w;
    int fd_seen, out_changed;
    w = 16'h1234;
    fd_seen = 0; out_changed = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      if (frame_done === 1'b1) fd_seen++;
    end
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    tests++;
    if (slot !== 4'd0 || busy !== 1'b0 || frame_done !== 1'b0 || out !== 16'hC3C3) begin
      fails++;
      $display("FAIL abort_clear: slot=%0d busy=%b fd=%b out=%h expected 0/0/0/c3c3", slot, busy, frame_done, out);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, w[i], 1'b0, 4'd0, 1'b0);
      if (i < 15 && frame_done === 1'b1) fd_seen++;
      if (i < 15 && out !== 16'hC3C3) out_changed++;
    end
    tests++;
    if (fd_seen !== 0 || out_changed !== 0) begin
      fails++;
      $display("FAIL abort_no_early_done: fd_seen=%0d out_changed=%0d expected 0/0", fd_seen, out_changed);
    end
    tests++;
    if (out !== 16'h1234 || frame_done !== 1'b1) begin
      fails++;
      $display("FAIL abort_next_frame: out=%h fd=%b expected 1234/1", out, frame_done);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
    tests++;
    if (out !== 16'h1234) begin
      fails++;
      $display("FAIL abort_addr_drop: out=%h expected 1234", out);
    end
  endtask

  task automatic test_reset_midframe;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out !== 16'h0000 || slot !== 4'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_midframe: out=%h slot=%0d busy=%b fd=%b expected 0000/0/0/0", out, slot, busy, frame_done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tests++;
    if (slot !== 4'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_restart: slot=%0d busy=%b expected 1/1", slot, busy);
    end
  endtask

  initial begin
    test_reset;
    test_auto_frame;
    test_back_to_back;
    test_gapped;
    test_addr_mode;
    test_abort;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
